bmu_ctz_seq: RTL and testbench
==============================

// Module: bmu_ctz_seq
// PURPOSE
//  Iterative count-trailing-zeros unit for the RISC-V bit-manipulation datapath.
//  It scans rs1 from the LSB end, STEP bits per cycle, and writes the count of trailing zeros to rd.
//  It sits beside the leading-zero counter and behind the BMU issue stage.
//  Operands arrive on a valid/ready handshake and results leave on a second valid/ready handshake.
// PARAMETERS
//  XLEN  32  operand width; must be a power of 2 and >= 8
//  STEP  4   bits examined per SCAN cycle; power of 2 that divides XLEN. N = XLEN/STEP chunks.
// PORTS
//  clk        in   1     clock, rising edge
//  rst_n      in   1     asynchronous active-low reset
//  in_valid   in   1     operand valid
//  in_ready   out  1     unit can accept an operand
//  in_op      in   1     0 = CTZ, 1 = PCNT (honoured only with BMU_PCNT_EN)
//  rs1        in   XLEN  source operand
//  out_valid  out  1     rd holds a valid result
//  out_ready  in   1     consumer accepts the result
//  rd         out  XLEN  result; bits above [$clog2(XLEN)] are always 0
//  busy       out  1     1 in SCAN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; in_ready=1; out_valid=0; busy=0; rd=0.
//   - Internal shift register, chunk index and count all clear.
//  FSM states: IDLE -> SCAN -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready at an edge: latch rs1 into the shift register and latch in_op.
//   - Set count=0 and chunk k=0, then go to SCAN. This is cycle 0.
//  SCAN, CTZ mode:
//   - Chunk k (low STEP bits of the shift register) is examined in cycle k+1.
//   - Chunk nonzero: result = k*STEP + index of its lowest set bit; go to DONE.
//   - Chunk zero: shift right by STEP and increment k.
//   - Zero after k=N-1: result = XLEN; go to DONE.
//  SCAN, PCNT mode:
//   - All N chunks are scanned with no early exit; count += popcount(chunk).
//   - Go to DONE after chunk N-1.
//  Latency:
//   - CTZ: out_valid rises in cycle k+2, where k = index of the first nonzero chunk.
//   - CTZ with zero operand: cycle N+1.
//   - PCNT: always cycle N+1.
//  DONE:
//   - out_valid=1. rd is registered and holds stable until out_valid&&out_ready.
//   - On that handshake go to IDLE. out_valid=0 and in_ready=1 in the next cycle.
//  Handshake rules:
//   - in_ready=0 in SCAN and DONE; there is no overlap of operations.
//   - in_valid and rs1 are ignored when in_ready=0.
//   - out_ready is ignored when out_valid=0.
//   - The unit completes one result per handshake; results are never dropped or duplicated.
//  Boundaries:
//   - Bit 0 set: rd=0 in cycle 2.
//   - Only MSB set: rd=XLEN-1 in cycle N+1.
//   - rd width: the max value XLEN needs $clog2(XLEN)+1 bits (6 bits for XLEN=32).
//   - rst_n low mid-SCAN or mid-DONE: the operation is abandoned and all outputs go to reset values immediately.
//   - rst_n low in the same cycle as an out handshake: reset wins.
// CONFIGURATION
//  BMU_PCNT_EN defined:
//   - in_op=1 selects PCNT mode as described above.
//   - Adds a STEP-bit popcount adder and the in_op latch.
//  BMU_PCNT_EN undefined:
//   - in_op is ignored (port kept) and every operation is CTZ.
//   - No popcount logic is built.
// TESTING (XLEN=32, STEP=4, N=8)
//  1. rs1=0x0000_0001 -> rd=0, out_valid in cycle 2.
//  2. rs1=0x0001_0000 -> rd=16, out_valid in cycle 6.
//  3. rs1=0x8000_0000 -> rd=31, cycle 9.
//     rs1=0x0000_0000 -> rd=32, cycle 9.
//  4. rs1=0x0000_0100, out_ready held 0 for 5 cycles after out_valid ->
//     rd=8 stable, in_ready=0 throughout; after the handshake, in_ready=1 next cycle.
//     A back-to-back operand is then accepted.
//  5. rst_n pulsed low in cycle 3 of rs1=0 -> out_valid=0, rd=0, in_ready=1 immediately.
//     No stale result after release; next rs1=0x0000_0040 -> rd=6.
//  6. BMU_PCNT_EN defined, in_op=1, rs1=0xF0F0_0001 -> rd=9, cycle 9.
//     Undefined: same stimulus -> rd=0, cycle 2.

Source files
------------

// File: rtl/bmu_ctz_seq.sv
// Iterative count-trailing-zeros unit that scans rs1 STEP bits per cycle from the LSB end.
// Optional population-count mode is built when BMU_PCNT_EN is defined.
module bmu_ctz_seq #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_op,
  input  logic [XLEN-1:0] rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            busy
);

  localparam int unsigned N  = XLEN / STEP;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int unsigned RW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_sh;
  logic [KW-1:0]     r_k;
  logic [XLEN-1:0]   r_rd;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [STEP-1:0]   w_chunk;
  logic [SW-1:0]     w_idx;
  logic [RW-1:0]     w_ctz;
  logic              w_last;

`ifdef BMU_PCNT_EN
  logic              r_op;
  logic [RW-1:0]     r_cnt;
  logic [RW-1:0]     w_pop;
  logic [RW-1:0]     w_cnt_nxt;
`else
  logic              w_unused;
  assign w_unused = in_op;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign rd        = r_rd;
  assign busy      = r_busy;

  assign w_chunk = r_sh[STEP-1:0];
  assign w_last  = (r_k == KW'(N - 1));

  // Lowest set bit of the current chunk: scan down so the lowest index wins.
  always_comb begin
    w_idx = '0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (w_chunk[i]) w_idx = SW'(i);
    end
  end

  assign w_ctz = RW'(r_k) * RW'(STEP) + RW'(w_idx);

`ifdef BMU_PCNT_EN
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < STEP; i++) begin
      w_pop = w_pop + RW'(w_chunk[i]);
    end
  end

  assign w_cnt_nxt = r_cnt + w_pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_k         <= '0;
      r_rd        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef BMU_PCNT_EN
      r_op        <= 1'b0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sh       <= rs1;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_SCAN;
`ifdef BMU_PCNT_EN
            r_op       <= in_op;
            r_cnt      <= '0;
`endif
          end
        end
        S_SCAN: begin
`ifdef BMU_PCNT_EN
          // Popcount walks every chunk; no early exit.
          if (r_op) begin
            r_cnt <= w_cnt_nxt;
            r_sh  <= r_sh >> STEP;
            r_k   <= r_k + KW'(1);
            if (w_last) begin
              r_rd        <= XLEN'(w_cnt_nxt);
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end else
`endif
          if (w_chunk != '0) begin
            r_rd        <= XLEN'(w_ctz);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_last) begin
            r_rd        <= XLEN'(RW'(XLEN));
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_sh <= r_sh >> STEP;
            r_k  <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmu_ctz_seq.sv
// Scoreboard bench for bmu_ctz_seq: driver pushes model results, a monitor pops on each out handshake.
// Expectations follow BMU_PCNT_EN when it is defined for the build.
module tb_bmu_ctz_seq;

  localparam int XLEN = 32;
  localparam int STEP = 4;
  localparam int N    = XLEN / STEP;

  typedef struct {
    logic [31:0] rd;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_op = 1'b0;
  logic [31:0] rs1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] rd;
  logic        busy;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_cmp = 0;
  int   hold = 0;
  bit   rand_ready = 1'b1;

  bmu_ctz_seq #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .rs1(rs1), .out_valid(out_valid), .out_ready(out_ready),
    .rd(rd), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: trailing zeros from the first set bit, latency from the chunk that holds it.
  function automatic void model(input logic [31:0] v, input logic op,
                                output logic [31:0] r, output int lat);
    int tz;
    tz = XLEN;
    for (int i = XLEN - 1; i >= 0; i--) if (v[i]) tz = i;
    r   = 32'(tz);
    lat = (v == 0) ? N : (tz / STEP) + 1;
`ifdef BMU_PCNT_EN
    if (op) begin
      r   = 32'($countones(v));
      lat = N;
    end
`else
    if (op) r = r;
`endif
  endfunction

  task automatic issue(input logic [31:0] val, input logic op);
    int   waited;
    bit   ok;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    rs1      = $urandom;
    in_op    = 1'($urandom);
    waited   = 0;
    ok       = 1'b0;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        rs1   = val;
        in_op = op;
        ok    = 1'b1;
      end else begin
        rs1   = $urandom;
        in_op = 1'($urandom);
        waited++;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
    end else begin
      model(val, op, e.rd, e.lat);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rs1      = $urandom;
  endtask

  // Consumer side: optional directed stall, otherwise random or always-ready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else if (rand_ready) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  bit          mon_active = 1'b0;
  bit          post_hs = 1'b0;
  int          first_cyc;
  logic [31:0] first_rd;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (post_hs) begin
          chk("in_ready_after_hs", in_ready, 1);
          chk("out_valid_after_hs", out_valid, 0);
          post_hs = 1'b0;
        end
        if (out_valid) begin
          if (!mon_active) begin
            mon_active = 1'b1;
            first_cyc  = cyc;
            first_rd   = rd;
          end else begin
            chk("rd_stable", rd, first_rd);
          end
          chk("in_ready_in_done", in_ready, 0);
          chk("busy_in_done", busy, 1);
          if (out_ready) begin
            if (exp_q.size() == 0) begin
              chk("spurious_result", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("rd", rd, e.rd);
              chk("latency", first_cyc - e.acc, e.lat);
              n_vec++;
            end
            mon_active = 1'b0;
            post_hs    = 1'b1;
          end
        end
      end else begin
        mon_active = 1'b0;
        post_hs    = 1'b0;
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [31:0] v;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed boundaries.
    issue(32'h0000_0001, 1'b0);
    issue(32'h0001_0000, 1'b0);
    issue(32'h8000_0000, 1'b0);
    issue(32'h0000_0000, 1'b0);
    drain();

    // Held consumer, then a back-to-back operand.
    rand_ready = 1'b0;
    hold = 5;
    issue(32'h0000_0100, 1'b0);
    issue(32'h0000_0020, 1'b0);
    drain();
    rand_ready = 1'b1;

    // Reset in cycle 3 of a zero operand.
    issue(32'h0000_0000, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midscan_rst_out_valid", out_valid, 0);
    chk("midscan_rst_rd", rd, 0);
    chk("midscan_rst_in_ready", in_ready, 1);
    chk("midscan_rst_busy", busy, 0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    issue(32'h0000_0040, 1'b0);
    drain();

    // Popcount request (CTZ when the feature is not built).
    issue(32'hF0F0_0001, 1'b1);
    drain();

    // Randomized operands across all chunk positions.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 4))
        0:       v = 32'h0;
        1:       v = 32'h1 << $urandom_range(0, 31);
        default: v = $urandom << $urandom_range(0, 31);
      endcase
      issue(v, 1'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d pending expected 0", exp_q.size());
    $fatal(1, "timeout");
  end

endmodule
